// File: rtl/soc_rst_ctrl_if.sv
// Side-band between the reset sequencer and the SoC: synchronous reset requests in,
// reset / clock-enable / cause status out.
interface soc_rst_ctrl_if;
    logic       sw_rst_req_i;
    logic       wdt_rst_req_i;
    logic       rst_cause_clr_i;
    logic       clk_en_o;
    logic       periph_rst_no;
    logic       core_rst_no;
    logic [4:0] rst_cause_o;
    logic       busy_o;

    modport master (
        output sw_rst_req_i, wdt_rst_req_i, rst_cause_clr_i,
        input  clk_en_o, periph_rst_no, core_rst_no, rst_cause_o, busy_o
    );

    modport slave (
        input  sw_rst_req_i, wdt_rst_req_i, rst_cause_clr_i,
        output clk_en_o, periph_rst_no, core_rst_no, rst_cause_o, busy_o
    );
endinterface

// File: rtl/soc_rst_ctrl.sv
// SoC reset sequencer: waits for clock lock, stretches reset, releases peripherals before
// the core, and records the reason for every re-entry into reset.
module soc_rst_ctrl #(
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STRETCH_CYCLES  = 32,
    parameter int unsigned STAGGER_CYCLES  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          locked_i,
    input  logic          ext_rst_req_i,
    soc_rst_ctrl_if.slave rst_if
);
    localparam int unsigned CntMax = (STRETCH_CYCLES > STAGGER_CYCLES) ?
                                     STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CntW-1:0] StretchLast = CntW'(STRETCH_CYCLES - 1);
    localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);
    localparam logic [DebW-1:0] DebLast     = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast     = DivW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StWaitLock, StStretch, StRelPeriph, StRun} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_lock_meta, r_lock_s, r_ext_meta, r_ext_s;
    logic [DebW-1:0] r_deb_cnt;
    logic [DivW-1:0] r_div_cnt;
    logic            r_clk_en, r_periph_rst_n, r_core_rst_n, r_busy;
    logic [4:0]      r_cause, w_cause_d, w_cause_set;
    logic            w_periph_rst_n_d, w_core_rst_n_d, w_busy_d;
    logic            w_ext_req, w_ev, w_lock_lost;

    // Synchronisers, button debounce and free-running clock-enable divider.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_ext_meta  <= 1'b0;
            r_ext_s     <= 1'b0;
            r_deb_cnt   <= '0;
            r_div_cnt   <= '0;
            r_clk_en    <= 1'b0;
        end else begin
            r_lock_meta <= locked_i;
            r_lock_s    <= r_lock_meta;
            r_ext_meta  <= ext_rst_req_i;
            r_ext_s     <= r_ext_meta;
            if (!r_ext_s) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt != DebLast) begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
            r_div_cnt <= (r_div_cnt == DivLast) ? '0 : r_div_cnt + 1'b1;
            r_clk_en  <= (r_div_cnt == DivLast) && r_lock_s;
        end
    end

    // A single-cycle debounce window degenerates to the synced level itself.
    assign w_ext_req   = (DEBOUNCE_CYCLES == 1) ? r_ext_s : (r_deb_cnt == DebLast);
    assign w_ev        = w_ext_req | rst_if.sw_rst_req_i | rst_if.wdt_rst_req_i;
    assign w_lock_lost = !r_lock_s && (r_state != StWaitLock);

    // State register plus registered outputs and cause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= StWaitLock;
            r_cnt          <= '0;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_busy         <= 1'b1;
            r_cause        <= 5'b00001;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_periph_rst_n <= w_periph_rst_n_d;
            r_core_rst_n   <= w_core_rst_n_d;
            r_busy         <= w_busy_d;
            r_cause        <= w_cause_d;
        end
    end

    // Next state; lock loss outranks every reset event.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (!r_lock_s) begin
            w_state_d = StWaitLock;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                StWaitLock: begin
                    w_state_d = StStretch;
                    w_cnt_d   = '0;
                end
                StStretch: begin
                    if (w_ev) begin
                        w_cnt_d = '0;
                    end else if (r_cnt == StretchLast) begin
                        w_state_d = StRelPeriph;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StRelPeriph: begin
                    if (w_ev) begin
                        w_state_d = StStretch;
                        w_cnt_d   = '0;
                    end else if (r_cnt == StaggerLast) begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (w_ev) begin
                        w_state_d = StStretch;
                        w_cnt_d   = '0;
                    end
                end
            endcase
        end
    end

    // Output decode from the next state so the flops track the state register exactly.
    always_comb begin
        w_periph_rst_n_d = (w_state_d == StRelPeriph) || (w_state_d == StRun);
        w_core_rst_n_d   = (w_state_d == StRun);
        w_busy_d         = (w_state_d != StRun);
    end

    always_comb begin
        w_cause_set = {w_lock_lost, rst_if.wdt_rst_req_i, rst_if.sw_rst_req_i, w_ext_req, 1'b0};
        if (rst_if.rst_cause_clr_i && (r_state == StRun)) begin
            w_cause_d = w_cause_set;
        end else begin
            w_cause_d = r_cause | w_cause_set;
        end
    end

    assign rst_if.clk_en_o      = r_clk_en;
    assign rst_if.periph_rst_no = r_periph_rst_n;
    assign rst_if.core_rst_no   = r_core_rst_n;
    assign rst_if.busy_o        = r_busy;
    assign rst_if.rst_cause_o   = r_cause;
endmodule

// File: tb/tb_soc_rst_ctrl.sv
// Directed bench for soc_rst_ctrl at default parameters; edge numbers in tags count rising
// edges since the stimulus step that started each sequence.
module tb_soc_rst_ctrl;
    logic clk;
    logic rst_n;
    logic locked_i;
    logic ext_rst_req_i;

    int n_compared   = 0;
    int n_mismatched = 0;

    soc_rst_ctrl_if u_if ();

    soc_rst_ctrl u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .locked_i      (locked_i),
        .ext_rst_req_i (ext_rst_req_i),
        .rst_if        (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_clk_en"}, u_if.clk_en_o, 0);
        check_eq({tag, "_periph"}, u_if.periph_rst_no, 0);
        check_eq({tag, "_core"}, u_if.core_rst_no, 0);
        check_eq({tag, "_busy"}, u_if.busy_o, 1);
        check_eq({tag, "_cause"}, u_if.rst_cause_o, 5'b00001);
    endtask

    initial begin
        int n_hi;
        logic [2:0] acc;

        rst_n = 1'b0;
        locked_i = 1'b1;
        ext_rst_req_i = 1'b0;
        u_if.sw_rst_req_i = 1'b0;
        u_if.wdt_rst_req_i = 1'b0;
        u_if.rst_cause_clr_i = 1'b0;
        tick(3);
        check_reset_vals("por");

        // Power-on with lock present: periph after edge 35, core after edge 43.
        rst_n = 1'b1;
        tick(34); check_eq("por_periph_e34", u_if.periph_rst_no, 0);
        tick(1);  check_eq("por_periph_e35", u_if.periph_rst_no, 1);
        check_eq("por_core_e35", u_if.core_rst_no, 0);
        tick(7);  check_eq("por_core_e42", u_if.core_rst_no, 0);
        tick(1);  check_eq("por_core_e43", u_if.core_rst_no, 1);
        check_eq("por_busy_e43", u_if.busy_o, 0);
        check_eq("por_cause", u_if.rst_cause_o, 5'b00001);
        check_eq("por_clk_en_e43", u_if.clk_en_o, 0);
        tick(1);  check_eq("por_clk_en_e44", u_if.clk_en_o, 1);

        // Software reset; clear ignored outside RUN, honoured in RUN.
        u_if.sw_rst_req_i = 1'b1; tick(1); u_if.sw_rst_req_i = 1'b0;
        check_eq("sw_periph", u_if.periph_rst_no, 0);
        check_eq("sw_core", u_if.core_rst_no, 0);
        check_eq("sw_cause", u_if.rst_cause_o, 5'b00101);
        u_if.rst_cause_clr_i = 1'b1; tick(1); u_if.rst_cause_clr_i = 1'b0;
        check_eq("sw_clr_ignored", u_if.rst_cause_o, 5'b00101);
        check_eq("sw_busy", u_if.busy_o, 1);
        tick(38); check_eq("sw_core_e39", u_if.core_rst_no, 0);
        tick(1);  check_eq("sw_core_e40", u_if.core_rst_no, 1);
        u_if.rst_cause_clr_i = 1'b1; tick(1); u_if.rst_cause_clr_i = 1'b0;
        check_eq("run_clr", u_if.rst_cause_o, 5'b00000);

        // Clear and watchdog in the same RUN cycle: only the watchdog bit survives.
        u_if.rst_cause_clr_i = 1'b1; u_if.wdt_rst_req_i = 1'b1; tick(1);
        u_if.rst_cause_clr_i = 1'b0; u_if.wdt_rst_req_i = 1'b0;
        check_eq("clr_wdt_cause", u_if.rst_cause_o, 5'b01000);
        check_eq("clr_wdt_core", u_if.core_rst_no, 0);
        tick(40); check_eq("clr_wdt_core_e40", u_if.core_rst_no, 1);

        // Short button glitch must be filtered out.
        ext_rst_req_i = 1'b1; tick(10); ext_rst_req_i = 1'b0; tick(10);
        check_eq("glitch_core", u_if.core_rst_no, 1);
        check_eq("glitch_cause", u_if.rst_cause_o, 5'b01000);

        // Held button: reset 18 edges in, held, released 32/40 edges after ext_req drops.
        ext_rst_req_i = 1'b1;
        tick(17); check_eq("ext_periph_e17", u_if.periph_rst_no, 1);
        tick(1);  check_eq("ext_periph_e18", u_if.periph_rst_no, 0);
        check_eq("ext_core_e18", u_if.core_rst_no, 0);
        check_eq("ext_cause", u_if.rst_cause_o, 5'b01010);
        tick(182); check_eq("ext_periph_e200", u_if.periph_rst_no, 0);
        ext_rst_req_i = 1'b0;
        tick(34); check_eq("ext_periph_e234", u_if.periph_rst_no, 0);
        tick(1);  check_eq("ext_periph_e235", u_if.periph_rst_no, 1);
        tick(7);  check_eq("ext_core_e242", u_if.core_rst_no, 0);
        tick(1);  check_eq("ext_core_e243", u_if.core_rst_no, 1);

        // Watchdog during REL_PERIPH at cnt=5 restarts the full stretch.
        u_if.rst_cause_clr_i = 1'b1; tick(1); u_if.rst_cause_clr_i = 1'b0;
        check_eq("rel_clr", u_if.rst_cause_o, 5'b00000);
        u_if.sw_rst_req_i = 1'b1; tick(1); u_if.sw_rst_req_i = 1'b0;
        tick(31); check_eq("rel_periph_e31", u_if.periph_rst_no, 0);
        tick(1);  check_eq("rel_periph_e32", u_if.periph_rst_no, 1);
        tick(5);
        u_if.wdt_rst_req_i = 1'b1; tick(1); u_if.wdt_rst_req_i = 1'b0;
        check_eq("rel_wdt_periph", u_if.periph_rst_no, 0);
        check_eq("rel_wdt_core", u_if.core_rst_no, 0);
        check_eq("rel_wdt_cause", u_if.rst_cause_o, 5'b01100);
        tick(39); check_eq("rel_periph_e77", u_if.periph_rst_no, 1);
        check_eq("rel_core_e77", u_if.core_rst_no, 0);
        tick(1);  check_eq("rel_core_e78", u_if.core_rst_no, 1);

        // Lock loss in RUN: WAIT_LOCK after the synchroniser delay, clk_en stops.
        locked_i = 1'b0;
        tick(2); check_eq("lock_core_e2", u_if.core_rst_no, 1);
        tick(1); check_eq("lock_core_e3", u_if.core_rst_no, 0);
        check_eq("lock_periph_e3", u_if.periph_rst_no, 0);
        check_eq("lock_busy", u_if.busy_o, 1);
        check_eq("lock_cause", u_if.rst_cause_o, 5'b11100);
        n_hi = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (u_if.clk_en_o) n_hi++;
        end
        check_eq("lock_clk_en_quiet", n_hi, 0);

        // Late lock after a fresh power-on reset.
        rst_n = 1'b0; tick(2);
        check_reset_vals("por2");
        rst_n = 1'b1;
        acc = 3'b000;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            acc = acc | {u_if.clk_en_o, u_if.periph_rst_no, u_if.core_rst_no};
        end
        check_eq("nolock_outputs", acc, 3'b000);
        locked_i = 1'b1;
        tick(3); check_eq("late_clk_en_e103", u_if.clk_en_o, 0);
        tick(1); check_eq("late_clk_en_e104", u_if.clk_en_o, 1);
        tick(1); check_eq("late_clk_en_e105", u_if.clk_en_o, 0);
        n_hi = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (u_if.clk_en_o) n_hi++;
        end
        check_eq("late_clk_en_count", n_hi, 4);
        tick(13); check_eq("late_periph_e134", u_if.periph_rst_no, 0);
        tick(1);  check_eq("late_periph_e135", u_if.periph_rst_no, 1);
        check_eq("late_cause", u_if.rst_cause_o, 5'b00001);

        // rst_n pulled low during STRETCH.
        u_if.wdt_rst_req_i = 1'b1; tick(1); u_if.wdt_rst_req_i = 1'b0;
        check_eq("mid_periph", u_if.periph_rst_no, 0);
        check_eq("mid_cause", u_if.rst_cause_o, 5'b01001);
        tick(5);
        rst_n = 1'b0; tick(1);
        check_reset_vals("mid_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/soc_rst_ctrl.md
Name: soc_rst_ctrl

Overview:
- Reset and clock-enable sequencer for the MCU SoC. It replaces the free-running divider and bare reset inversion at SoC top.
- Waits for clock lock, then stretches reset and releases peripheral reset before core reset.
- Re-enters reset on external button, software, watchdog or lock-loss events, and records the cause in a sticky register.
- Sits between the board pins and mcu_top; drives the peripheral and core resets and a divided clock enable.

Parameters:
- CLK_DIV, 4, clk_en_o period in clk cycles (>=1).
- DEBOUNCE_CYCLES, 16, consecutive synced-high cycles before ext_rst_req_i is recognised (>=1).
- STRETCH_CYCLES, 32, cycles both resets stay asserted after the last reset event (>=1).
- STAGGER_CYCLES, 8, cycles between peripheral and core reset release (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  power-on reset, synchronous, active-low.
- locked_i  in  1  clock-source lock, asynchronous.
- ext_rst_req_i  in  1  board reset button, asynchronous, active-high.
- sw_rst_req_i  in  1  core software reset request, single-cycle pulse, synchronous.
- wdt_rst_req_i  in  1  watchdog reset request, single-cycle pulse, synchronous.
- rst_cause_clr_i  in  1  clear cause register, synchronous.
- clk_en_o  out  1  clock-enable pulse for slow logic.
- periph_rst_no  out  1  peripheral reset, active-low.
- core_rst_no  out  1  core reset, active-low.
- rst_cause_o  out  5  sticky cause: [0] POR, [1] ext, [2] sw, [3] wdt, [4] lock loss.
- busy_o  out  1  high while not in RUN.

Behaviour:
- One clock. Reset is synchronous and active-low on rst_n. All outputs are registered.
- While rst_n=0:
  - State is WAIT_LOCK and all counters and synchroniser flops are 0.
  - clk_en_o=0, periph_rst_no=0, core_rst_no=0, busy_o=1.
  - rst_cause_o=5'b00001.
- Synchronisers:
  - locked_i and ext_rst_req_i each pass through a 2-flop synchroniser.
  - lock_s and ext_s denote the synchroniser outputs.
- Debounce:
  - A counter increments while ext_s=1 and clears to 0 when ext_s=0.
  - ext_req is high while the counter equals DEBOUNCE_CYCLES-1. The counter saturates there.
- Clock enable:
  - The divider counts 0..CLK_DIV-1 and wraps, free-running whenever rst_n=1.
  - clk_en_o=1 on the cycle after the counter equals CLK_DIV-1, and only while lock_s=1.
  - With CLK_DIV=1, clk_en_o equals lock_s delayed by one cycle.
- The reset event ev is the OR of ext_req, sw_rst_req_i and wdt_rst_req_i.
- FSM states: WAIT_LOCK, STRETCH, REL_PERIPH, RUN.
  - WAIT_LOCK: go to STRETCH with cnt=0 when lock_s=1.
  - STRETCH: cnt increments each cycle. At cnt==STRETCH_CYCLES-1, go to REL_PERIPH with cnt=0. ev restarts cnt at 0. A held ext_req keeps cnt at 0 indefinitely.
  - REL_PERIPH: cnt increments each cycle. At cnt==STAGGER_CYCLES-1, go to RUN. ev returns to STRETCH with cnt=0.
  - RUN: ev goes to STRETCH with cnt=0.
  - In any state, lock_s=0 goes to WAIT_LOCK. Lock loss has priority over ev.
- Output decode (registered from state):
  - periph_rst_no=1 in REL_PERIPH and RUN.
  - core_rst_no=1 in RUN only.
  - busy_o=1 in every state except RUN.
- Both resets reassert on the cycle after the transition edge into STRETCH or WAIT_LOCK.
- Cause register:
  - Bits set on their event in any state: ext_req→[1], sw→[2], wdt→[3].
  - Bit [4] sets when lock_s falls while not in WAIT_LOCK.
  - Bits are sticky.
  - rst_cause_clr_i clears all bits only when state==RUN. It is ignored in other states.
  - A clear and a new event in the same cycle: the event's bit ends set, all other bits clear.
- Latency: with locked_i=1 from reset release, edge 1 is the first rising edge with rst_n=1.
  - periph_rst_no rises after edge 3+STRETCH_CYCLES.
  - core_rst_no rises STAGGER_CYCLES cycles later.
- rst_n low mid-sequence returns everything to the reset values above within one edge.

Test Plan:
- POR, locked_i=1, defaults → periph_rst_no rises after edge 35, core_rst_no after edge 43, rst_cause_o=5'b00001, busy_o falls with core_rst_no.
- locked_i=0 for 100 cycles after reset, then 1 → both resets stay 0 and clk_en_o stays 0 until lock. After lock_s rises, clk_en_o pulses every 4 cycles and periph_rst_no rises 33 edges after lock_s rises.
- In RUN, sw_rst_req_i pulse → both resets 0 next cycle, rst_cause_o[2]=1. Then rst_cause_clr_i is ignored (not in RUN). After 32+8 cycles core_rst_no=1; rst_cause_clr_i then clears all bits to 0.
- ext_rst_req_i glitch high for 10 cycles → no reset, cause unchanged. Held high for 200 cycles → reset asserts 18 cycles after assertion, stays asserted while held, and releases 32/40 cycles after ext_req drops.
- wdt_rst_req_i pulse during REL_PERIPH at cnt=5 → back to STRETCH, core_rst_no never rises early, rst_cause_o[3]=1.
- In RUN, drop locked_i → WAIT_LOCK, rst_cause_o[4]=1, clk_en_o=0. Also assert rst_n=0 during STRETCH → all outputs at reset values after one edge.
